// File: rtl/gpio_pkg.sv
// gpio_pkg: shared opcodes, command-field positions and bank limits for the GPIO bank
package gpio_pkg;
    localparam int MAX_PINS = 16;
    localparam int PIN_HI   = 15;
    localparam int PIN_LO   = 12;
    localparam int OP_HI    = 11;
    localparam int OP_LO    = 9;
    localparam int ARG_HI   = 8;
    localparam int ARG_LO   = 0;
    localparam int PIN_W    = PIN_HI - PIN_LO + 1;
    localparam int ARG_W    = ARG_HI - ARG_LO + 1;
    typedef enum logic [2:0] {
        WRITE_BIT   = 3'd0,
        RELEASE     = 3'd1,
        TOGGLE      = 3'd2,
        READ_PIN    = 3'd3,
        READ_STATUS = 3'd4,
        READ_BANK   = 3'd5,
        READ_EDGES  = 3'd6,
        PULSE       = 3'd7
    } opcode_e;
endpackage

// File: rtl/gpio_bank_controller_pin.sv
// gpio_pin_cell: one pin's output register, enable, pulse timer, input synchroniser and edge flag
module gpio_pin_cell #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 10
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic             clk_en,
    input  logic             din_i,
    input  logic             wr_bit_i,
    input  logic             wr_val_i,
    input  logic             release_i,
    input  logic             toggle_i,
    input  logic             pulse_i,
    input  logic [CNT_W-1:0] pulse_len_i,
    input  logic             edge_clr_i,
    output logic             out_reg_o,
    output logic             out_en_o,
    output logic             pulse_active_o,
    output logic             sync_o,
    output logic             edge_flag_o,
    output logic             dout_o
);
    logic                   out_reg_q, out_reg_d;
    logic                   out_en_q, out_en_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    // next state: commands are one-hot per cycle, a new edge beats a same-cycle clear
    always_comb begin
        out_reg_d = wr_bit_i ? wr_val_i : (toggle_i ? ~out_reg_q : out_reg_q);
        out_en_d  = (wr_bit_i || (pulse_i && pulse_len_i != '0)) ? 1'b1 : (release_i ? 1'b0 : out_en_q);
        cnt_d     = pulse_i ? pulse_len_i : (cnt_q != '0 ? cnt_q - CNT_W'(1) : cnt_q);
        sync_d    = {sync_q[SYNC_STAGES-2:0], din_i};
        edge_d    = (sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2]) | (edge_q & ~edge_clr_i);
    end
    // state register: reset wins over everything, nothing moves while clk_en is low
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            out_reg_q <= 1'b0;
            out_en_q  <= 1'b0;
            cnt_q     <= '0;
            sync_q    <= '0;
            edge_q    <= 1'b0;
        end else if (clk_en) begin
            out_reg_q <= out_reg_d;
            out_en_q  <= out_en_d;
            cnt_q     <= cnt_d;
            sync_q    <= sync_d;
            edge_q    <= edge_d;
        end
    end
    assign out_reg_o      = out_reg_q;
    assign out_en_o       = out_en_q;
    assign pulse_active_o = cnt_q != '0;
    assign sync_o         = sync_q[SYNC_STAGES-1];
    assign edge_flag_o    = edge_q;
    assign dout_o         = out_reg_q ^ pulse_active_o;
endmodule

// File: rtl/gpio_bank_controller.sv
// gpio_bank_controller: IO-bus command decode, read mux and pass-through for a bank of GPIO pin cells
module gpio_bank_controller
    import gpio_pkg::*;
#(
    parameter int PIN_COUNT      = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int PULSE_PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 sync_rst,
    input  logic                 clk_en,
    output logic                 IO_ACK,
    input  logic                 IO_REQ,
    input  logic                 IO_CommandEn,
    input  logic                 IO_ResponseRequested,
    output logic                 IO_CommandResponse,
    output logic                 IO_RegResponseFlag,
    output logic                 IO_MemResponseFlag,
    input  logic [3:0]           IO_DestRegIn,
    output logic [3:0]           IO_DestRegOut,
    input  logic [15:0]          IO_DataIn,
    output logic [15:0]          IO_DataOut,
    input  logic [PIN_COUNT-1:0] GPIO_DIn,
    output logic [PIN_COUNT-1:0] GPIO_DOut,
    output logic [PIN_COUNT-1:0] GPIO_DOutEn
);
    localparam int CNT_W = $clog2((2 ** ARG_W - 1) * PULSE_PRESCALE + 1);
    logic                 accept;
    logic [PIN_W-1:0]     pin;
    opcode_e              op;
    logic [ARG_W-1:0]     arg;
    logic [CNT_W-1:0]     pulse_len;
    logic [PIN_COUNT-1:0] pin_sel;
    logic [PIN_COUNT-1:0] reg_v, en_v, act_v, sync_v, edge_v;
    logic [MAX_PINS-1:0]  reg_w, en_w, act_w, sync_w, edge_w;
    assign accept    = IO_REQ && IO_CommandEn && clk_en;
    assign pin       = IO_DataIn[PIN_HI:PIN_LO];
    assign op        = opcode_e'(IO_DataIn[OP_HI:OP_LO]);
    assign arg       = IO_DataIn[ARG_HI:ARG_LO];
    assign pulse_len = CNT_W'(arg) * CNT_W'(PULSE_PRESCALE);
    // one-hot pin select; an index past the bank matches no cell, so the command is dropped
    always_comb begin
        pin_sel = '0;
        for (int k = 0; k < PIN_COUNT; k++) pin_sel[k] = accept && pin == PIN_W'(k);
    end
    for (genvar i = 0; i < PIN_COUNT; i++) begin : g_pin
        gpio_pin_cell #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) u_cell (
            .clk           (clk),
            .sync_rst      (sync_rst),
            .clk_en        (clk_en),
            .din_i         (GPIO_DIn[i]),
            .wr_bit_i      (pin_sel[i] && op == WRITE_BIT),
            .wr_val_i      (arg[0]),
            .release_i     (pin_sel[i] && op == RELEASE),
            .toggle_i      (pin_sel[i] && op == TOGGLE),
            .pulse_i       (pin_sel[i] && op == PULSE),
            .pulse_len_i   (pulse_len),
            .edge_clr_i    (accept && op == READ_EDGES),
            .out_reg_o     (reg_v[i]),
            .out_en_o      (en_v[i]),
            .pulse_active_o(act_v[i]),
            .sync_o        (sync_v[i]),
            .edge_flag_o   (edge_v[i]),
            .dout_o        (GPIO_DOut[i])
        );
    end
    assign GPIO_DOutEn = en_v;
    assign reg_w  = MAX_PINS'(reg_v);
    assign en_w   = MAX_PINS'(en_v);
    assign act_w  = MAX_PINS'(act_v);
    assign sync_w = MAX_PINS'(sync_v);
    assign edge_w = MAX_PINS'(edge_v);
    // read mux over pre-update state; zero padding makes out-of-range per-pin reads return 0
    always_comb begin
        IO_DataOut = '0;
        if (accept) begin
            case (op)
                READ_PIN:    IO_DataOut = {15'b0, sync_w[pin]};
                READ_STATUS: IO_DataOut = {13'b0, act_w[pin], en_w[pin], reg_w[pin]};
                READ_BANK:   IO_DataOut = sync_w;
                READ_EDGES:  IO_DataOut = edge_w;
                default:     IO_DataOut = '0;
            endcase
        end
    end
    assign IO_ACK             = clk_en;
    assign IO_CommandResponse = IO_CommandEn;
    assign IO_RegResponseFlag = IO_CommandEn && IO_ResponseRequested;
    assign IO_MemResponseFlag = 1'b0;
    assign IO_DestRegOut      = IO_DestRegIn;
endmodule

// File: tb/tb_gpio_bank_controller.sv
// tb_gpio_bank_controller: directed checks of an 8-pin and a 4-pin bank driven by one command stream
module tb_gpio_bank_controller;
    import gpio_pkg::*;
    logic        clk = 1'b0, rst = 1'b1, clk_en = 1'b1, req = 1'b0, cmd_en = 1'b1, resp_req = 1'b1;
    logic [3:0]  dest = 4'hA;
    logic [15:0] data = '0;
    logic [7:0]  din = '0;
    logic        ack, cresp, rflag, mflag, ack4, cresp4, rflag4, mflag4;
    logic [3:0]  dest_o, dest_o4;
    logic [15:0] bus, bus4, rd, rd4;
    logic        rf;
    logic [7:0]  gout, gen;
    logic [3:0]  gout4, gen4;
    int          checks = 0, errors = 0, n;

    gpio_bank_controller #(.PIN_COUNT(8), .SYNC_STAGES(2), .PULSE_PRESCALE(2)) dut (
        .clk(clk), .sync_rst(rst), .clk_en(clk_en), .IO_ACK(ack), .IO_REQ(req),
        .IO_CommandEn(cmd_en), .IO_ResponseRequested(resp_req), .IO_CommandResponse(cresp),
        .IO_RegResponseFlag(rflag), .IO_MemResponseFlag(mflag), .IO_DestRegIn(dest),
        .IO_DestRegOut(dest_o), .IO_DataIn(data), .IO_DataOut(bus), .GPIO_DIn(din),
        .GPIO_DOut(gout), .GPIO_DOutEn(gen)
    );
    gpio_bank_controller #(.PIN_COUNT(4), .SYNC_STAGES(2), .PULSE_PRESCALE(2)) dut4 (
        .clk(clk), .sync_rst(rst), .clk_en(clk_en), .IO_ACK(ack4), .IO_REQ(req),
        .IO_CommandEn(cmd_en), .IO_ResponseRequested(resp_req), .IO_CommandResponse(cresp4),
        .IO_RegResponseFlag(rflag4), .IO_MemResponseFlag(mflag4), .IO_DestRegIn(dest),
        .IO_DestRegOut(dest_o4), .IO_DataIn(data), .IO_DataOut(bus4), .GPIO_DIn(din[3:0]),
        .GPIO_DOut(gout4), .GPIO_DOutEn(gen4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cmd(input int pin, input opcode_e op, input int arg);
        @(negedge clk);
        req  = 1'b1;
        data = {4'(pin), op, 9'(arg)};
        #1;
        rd  = bus;
        rd4 = bus4;
        rf  = rflag;
        @(posedge clk);
        #1;
        req  = 1'b0;
        data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 16'(gout), 16'h0000);
        check("rst_douten", 16'(gen), 16'h0000);
        check("rst_bus", bus, 16'h0000);
        check("ack_follows_en", 16'(ack), 16'h0001);
        check("mem_flag", 16'(mflag), 16'h0000);
        rst = 1'b0;
        cmd(3, WRITE_BIT, 1);
        check("wb_rdata_zero", rd, 16'h0000);
        check("reg_resp_flag", 16'(rf), 16'h0001);
        check("dest_pass", 16'(dest_o), 16'h000A);
        check("wb_dout", 16'(gout), 16'h0008);
        check("wb_douten", 16'(gen), 16'h0008);
        cmd(3, READ_STATUS, 0);
        check("status_p3", rd, 16'h0003);
        cmd(2, PULSE, 5);
        n = 0;
        repeat (12) begin
            n += int'(gout[2]);
            tick();
        end
        check("pulse_len_10", 16'(n), 16'd10);
        check("pulse_end_low", 16'(gout[2]), 16'h0000);
        cmd(2, PULSE, 5);
        cmd(2, READ_STATUS, 0);
        check("status_pulsing", rd, 16'h0006);
        repeat (12) tick();
        cmd(1, PULSE, 100);
        repeat (7) tick();
        check("long_pulse_on", 16'(gout[1]), 16'h0001);
        cmd(1, PULSE, 0);
        check("cancel_dout", 16'(gout), 16'h0008);
        check("cancel_keeps_en", 16'(gen), 16'h000E);
        @(negedge clk) din[5] = 1'b1;
        repeat (2) @(posedge clk);
        cmd(0, READ_EDGES, 0);
        check("edges_p5", rd, 16'h0020);
        cmd(0, READ_EDGES, 0);
        check("edges_cleared", rd, 16'h0000);
        cmd(7, READ_BANK, 0);
        check("bank", rd, 16'h0020);
        cmd(5, READ_PIN, 0);
        check("readpin_p5", rd, 16'h0001);
        @(negedge clk) din[4] = 1'b1;
        @(posedge clk);
        cmd(0, READ_EDGES, 0);
        check("edge_race_read", rd, 16'h0000);
        cmd(0, READ_EDGES, 0);
        check("edge_race_kept", rd, 16'h0010);
        cmd(9, WRITE_BIT, 1);
        check("oor_dout", 16'(gout), 16'h0008);
        check("oor_douten", 16'(gen), 16'h000E);
        check("oor4_dout", 16'(gout4), 16'h0008);
        check("oor4_douten", 16'(gen4), 16'h000E);
        cmd(5, WRITE_BIT, 1);
        check("p5_dout", 16'(gout), 16'h0028);
        check("p5_douten", 16'(gen), 16'h002E);
        check("p5_dut4_ignored", 16'(gout4), 16'h0008);
        cmd(9, READ_PIN, 0);
        check("oor_readpin", rd, 16'h0000);
        cmd(5, READ_PIN, 0);
        check("dut8_pin5", rd, 16'h0001);
        check("dut4_pin5", rd4, 16'h0000);
        cmd(9, READ_STATUS, 0);
        check("oor_status", rd, 16'h0000);
        cmd(0, PULSE, 2);
        check("p0_pulse_on", 16'(gout[0]), 16'h0001);
        tick();
        @(negedge clk) clk_en = 1'b0;
        #1;
        check("ack_low", 16'(ack), 16'h0000);
        repeat (3) @(posedge clk);
        cmd(3, RELEASE, 0);
        check("gated_release", 16'(gen[3]), 16'h0001);
        check("frozen_pulse", 16'(gout[0]), 16'h0001);
        @(negedge clk) clk_en = 1'b1;
        n = 0;
        repeat (6) begin
            n += int'(gout[0]);
            tick();
        end
        check("resume_left_3", 16'(n), 16'd3);
        cmd(3, TOGGLE, 0);
        check("toggle_dout", 16'(gout), 16'h0020);
        cmd(3, RELEASE, 0);
        check("release_en", 16'(gen), 16'h0027);
        cmd(3, READ_STATUS, 0);
        check("release_status", rd, 16'h0000);
        cmd(6, PULSE, 3);
        check("p6_pulse", 16'(gout), 16'h0060);
        cmd(6, TOGGLE, 0);
        check("toggle_in_pulse", 16'(gout), 16'h0020);
        repeat (6) tick();
        check("after_pulse_level", 16'(gout), 16'h0060);
        cmd(1, PULSE, 50);
        check("p1_before_rst", 16'(gout[1]), 16'h0001);
        @(negedge clk) rst = 1'b1;
        cmd(4, WRITE_BIT, 1);
        check("rst_mid_dout", 16'(gout), 16'h0000);
        check("rst_mid_en", 16'(gen), 16'h0000);
        check("rst_dut4_dout", 16'(gout4), 16'h0000);
        rst = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
